// File: rtl/btu_untranspose_unit.sv
// Purpose : rebuilds packed n-bit lane words from R bit-plane rows (R = 2n for n>8, 4n for n<=8).
// Latency : first word one cycle after the last row handshake; R + NUM_WORDS (+1 start) cycles per block.
// Backpres: rows stall on !i_row_valid, words hold data/last stable while o_word_valid && !i_word_ready.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_start, i_n                  block start and lane bit width (1..16), sampled in IDLE
//   o_busy, o_err, o_done         not-idle flag, bad-width pulse, end-of-block pulse
//   i_row_valid/o_row_ready/i_row_data     bit-plane row input, bit j feeds word j
//   o_word_valid/i_word_ready/o_word_data/o_word_last   packed word output
module btu_untranspose_unit #(
    parameter int NUM_WORDS  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTPUT = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [4:0]            i_n,
    output logic                  o_busy,
    output logic                  o_err,
    input  logic                  i_row_valid,
    output logic                  o_row_ready,
    input  logic [NUM_WORDS-1:0]  i_row_data,
    output logic                  o_word_valid,
    input  logic                  i_word_ready,
    output logic [DATA_WIDTH-1:0] o_word_data,
    output logic                  o_word_last,
    output logic                  o_done
);

    localparam int WCW = $clog2(NUM_WORDS);
    localparam int RCW = $clog2(MAX_OUTPUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4:0]             r_n;
    logic [RCW-1:0]         r_rows;
    logic [RCW-1:0]         r_row_cnt;
    logic [WCW-1:0]         r_word_cnt;
    logic                   r_err;
    logic                   r_done;
    logic [NUM_WORDS-1:0]   r_buf [MAX_OUTPUT];

    logic                   w_n_ok;
    logic [RCW-1:0]         w_rows_calc;
    logic                   w_start_ok;
    logic                   w_row_hs;
    logic                   w_row_last;
    logic                   w_word_hs;
    logic                   w_word_last_hs;

    logic [MAX_OUTPUT-1:0]  w_col;
    logic [15:0]            w_mask;
    logic [5:0]             w_sh1;
    logic [5:0]             w_sh2;
    logic [5:0]             w_sh3;
    logic [15:0]            w_l0;
    logic [15:0]            w_l1;
    logic [7:0]             w_l2;
    logic [7:0]             w_l3;
    logic [DATA_WIDTH-1:0]  w_word;

    assign w_n_ok      = (i_n != 5'd0) && (i_n <= 5'd16);
    // Wide lanes split a word into two halves, narrow lanes into four bytes.
    assign w_rows_calc = (i_n > 5'd8) ? RCW'({i_n, 1'b0}) : RCW'({i_n, 2'b00});

    assign w_start_ok     = (r_state == S_IDLE) && i_start && w_n_ok;
    assign w_row_hs       = (r_state == S_COLLECT) && i_row_valid;
    assign w_row_last     = w_row_hs && (r_row_cnt == (r_rows - RCW'(1)));
    assign w_word_hs      = (r_state == S_EMIT) && i_word_ready;
    assign w_word_last_hs = w_word_hs && (r_word_cnt == WCW'(NUM_WORDS - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        o_busy       = 1'b0;
        o_row_ready  = 1'b0;
        o_word_valid = 1'b0;
        o_word_last  = 1'b0;
        o_word_data  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                o_busy      = 1'b1;
                o_row_ready = 1'b1;
                if (w_row_last) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                o_busy       = 1'b1;
                o_word_valid = 1'b1;
                o_word_last  = (r_word_cnt == WCW'(NUM_WORDS - 1));
                o_word_data  = w_word;
                if (w_word_last_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, latched width and status pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_n        <= '0;
            r_rows     <= '0;
            r_row_cnt  <= '0;
            r_word_cnt <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_err  <= (r_state == S_IDLE) && i_start && !w_n_ok;
            r_done <= w_word_last_hs;
            if (w_start_ok) begin
                r_n       <= i_n;
                r_rows    <= w_rows_calc;
                r_row_cnt <= '0;
            end
            if (w_row_hs) begin
                r_row_cnt <= r_row_cnt + RCW'(1);
            end
            if (w_row_last) begin
                r_word_cnt <= '0;
            end else if (w_word_hs) begin
                r_word_cnt <= r_word_cnt + WCW'(1);
            end
        end
    end

    // Row storage needs no reset: a block always overwrites every row it reads.
    always_ff @(posedge i_clk) begin
        if (w_row_hs) begin
            r_buf[r_row_cnt[RCW-2:0]] <= i_row_data;
        end
    end

    // Column of the current word: bit r is row r's contribution.
    always_comb begin
        w_col = '0;
        for (int r = 0; r < MAX_OUTPUT; r++) begin
            w_col[r] = r_buf[r][r_word_cnt];
        end
    end

    // Each lane is n consecutive column bits; the mask also hides stale rows >= R.
    assign w_mask = (16'd1 << r_n) - 16'd1;
    assign w_sh1  = {1'b0, r_n};
    assign w_sh2  = {r_n, 1'b0};
    assign w_sh3  = w_sh1 + w_sh2;
    assign w_l0   = 16'(w_col) & w_mask;
    assign w_l1   = 16'(w_col >> w_sh1) & w_mask;
    assign w_l2   = 8'(w_col >> w_sh2) & w_mask[7:0];
    assign w_l3   = 8'(w_col >> w_sh3) & w_mask[7:0];
    assign w_word = (r_n > 5'd8) ? {w_l0, w_l1}
                                 : {w_l0[7:0], w_l1[7:0], w_l2, w_l3};

    assign o_err  = r_err;
    assign o_done = r_done;

endmodule

// File: tb/tb_btu_untranspose_unit.sv
module tb_btu_untranspose_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [4:0]  i_n;
    logic        o_busy;
    logic        o_err;
    logic        i_row_valid;
    logic        o_row_ready;
    logic [31:0] i_row_data;
    logic        o_word_valid;
    logic        i_word_ready;
    logic [31:0] o_word_data;
    logic        o_word_last;
    logic        o_done;

    btu_untranspose_unit dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_n          (i_n),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .i_row_valid  (i_row_valid),
        .o_row_ready  (o_row_ready),
        .i_row_data   (i_row_data),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .o_word_data  (o_word_data),
        .o_word_last  (o_word_last),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] sb [$];
    logic [31:0] g_rows  [32];
    logic [31:0] g_words [32];
    bit          g_stall  = 1'b0;
    bit          g_hold   = 1'b0;
    bit          exp_done = 1'b0;
    bit          blk_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int rows_for(input int n);
        return (n > 8) ? 2 * n : 4 * n;
    endfunction

    task automatic push_words();
        for (int j = 0; j < 32; j++) sb.push_back({(j == 31), g_words[j]});
    endtask

    // Forward transpose: lanes of each word spread over bit-plane rows.
    task automatic transpose(input int n);
        for (int r = 0; r < 32; r++) g_rows[r] = $urandom;
        for (int j = 0; j < 32; j++) begin
            for (int b = 0; b < n; b++) begin
                if (n > 8) begin
                    g_rows[b][j]     = g_words[j][16 + b];
                    g_rows[n + b][j] = g_words[j][b];
                end else begin
                    g_rows[b][j]         = g_words[j][24 + b];
                    g_rows[n + b][j]     = g_words[j][16 + b];
                    g_rows[2 * n + b][j] = g_words[j][8 + b];
                    g_rows[3 * n + b][j] = g_words[j][b];
                end
            end
        end
    endtask

    task automatic rand_words(input int n);
        logic [15:0] m;
        logic [31:0] a, b;
        m = 16'((32'd1 << n) - 32'd1);
        for (int j = 0; j < 32; j++) begin
            a = $urandom;
            b = $urandom;
            if (n > 8) g_words[j] = {a[15:0] & m, b[15:0] & m};
            else       g_words[j] = {a[7:0] & m[7:0], a[23:16] & m[7:0], b[7:0] & m[7:0], b[23:16] & m[7:0]};
        end
    endtask

    task automatic start_block(input int n);
        @(negedge i_clk);
        i_start  = 1'b1;
        i_n      = 5'(n);
        blk_done = 1'b0;
        @(negedge i_clk);
        i_start  = 1'b0;
    endtask

    // Called at a negedge; handshake decided from ready, which is stable until the next posedge.
    task automatic send_rows(input int count);
        int r = 0;
        int guard = 0;
        bit hs;
        while (r < count && guard < 1000) begin
            i_row_valid = g_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            i_row_data  = g_rows[r];
            hs = i_row_valid && o_row_ready;
            @(negedge i_clk);
            if (hs) r++;
            guard++;
        end
        i_row_valid = 1'b0;
        if (guard >= 1000) chk("row_timeout", 1, 0);
    endtask

    task automatic wait_block();
        int guard = 0;
        while ((sb.size() != 0 || !blk_done) && guard < 2000) begin
            @(negedge i_clk);
            guard++;
        end
        if (guard >= 2000) chk("block_timeout", 1, 0);
        chk("busy_end", 32'(o_busy), 0);
    endtask

    task automatic run_block(input int n);
        start_block(n);
        send_rows(rows_for(n));
        chk("collect_end", 32'(o_row_ready), 0);
        wait_block();
    endtask

    // Word consumer / scoreboard
    initial begin
        i_word_ready = 1'b0;
        forever begin
            @(negedge i_clk);
            if (g_hold) begin
                i_word_ready = 1'b0;
            end else begin
                i_word_ready = g_stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (exp_done) begin
                    chk("done_pulse", 32'(o_done), 1);
                    exp_done = 1'b0;
                    blk_done = 1'b1;
                end
                if (o_word_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_word", 1, 0);
                    end else if (i_word_ready) begin
                        logic [32:0] e;
                        e = sb.pop_front();
                        chk("word", o_word_data, e[31:0]);
                        chk("last", 32'(o_word_last), 32'(e[32]));
                        if (e[32]) exp_done = 1'b1;
                    end else begin
                        chk("stall_hold", o_word_data, sb[0][31:0]);
                        chk("stall_last", 32'(o_word_last), 32'(sb[0][32]));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nlist [6] = '{1, 5, 8, 9, 13, 16};
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_n         = '0;
        i_row_valid = 1'b0;
        i_row_data  = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_busy",  32'(o_busy), 0);
        chk("rst_err",   32'(o_err), 0);
        chk("rst_rrdy",  32'(o_row_ready), 0);
        chk("rst_wvld",  32'(o_word_valid), 0);
        chk("rst_wdat",  o_word_data, 0);
        chk("rst_wlast", 32'(o_word_last), 0);
        chk("rst_done",  32'(o_done), 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // 1: n=8, row0 all ones
        for (int r = 0; r < 32; r++) g_rows[r] = '0;
        g_rows[0] = 32'hFFFF_FFFF;
        for (int j = 0; j < 32; j++) g_words[j] = 32'h0100_0000;
        push_words();
        run_block(8);

        // 2: n=16, bit 5 of rows 0 and 16
        for (int r = 0; r < 32; r++) g_rows[r] = '0;
        g_rows[0]  = 32'h0000_0020;
        g_rows[16] = 32'h0000_0020;
        for (int j = 0; j < 32; j++) g_words[j] = '0;
        g_words[5] = 32'h0001_0001;
        push_words();
        run_block(16);

        // 3: n=3, row11 all ones
        for (int r = 0; r < 32; r++) g_rows[r] = '0;
        g_rows[11] = 32'hFFFF_FFFF;
        for (int j = 0; j < 32; j++) g_words[j] = 32'h0000_0004;
        push_words();
        run_block(3);

        // 5: round trips without stalls
        foreach (nlist[k]) begin
            rand_words(nlist[k]);
            transpose(nlist[k]);
            push_words();
            run_block(nlist[k]);
        end

        // 4: round trips with random stalls on both sides
        g_stall = 1'b1;
        foreach (nlist[k]) begin
            rand_words(nlist[k]);
            transpose(nlist[k]);
            push_words();
            run_block(nlist[k]);
        end
        g_stall = 1'b0;

        // 6a: reset mid-COLLECT
        rand_words(9);
        transpose(9);
        start_block(9);
        send_rows(5);
        chk("mid_collect_busy", 32'(o_busy), 1);
        i_rst = 1'b1;
        #1;
        chk("rstc_busy", 32'(o_busy), 0);
        chk("rstc_rrdy", 32'(o_row_ready), 0);
        chk("rstc_wvld", 32'(o_word_valid), 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // 6b: reset mid-EMIT, words held back
        g_hold = 1'b1;
        rand_words(4);
        for (int j = 0; j < 32; j++) g_words[j] = g_words[j] | 32'h0101_0101;
        transpose(4);
        start_block(4);
        send_rows(16);
        @(negedge i_clk);
        chk("mid_emit_wvld", 32'(o_word_valid), 1);
        chk("mid_emit_wdat", o_word_data, g_words[0]);
        i_rst = 1'b1;
        #1;
        chk("rste_busy",  32'(o_busy), 0);
        chk("rste_wvld",  32'(o_word_valid), 0);
        chk("rste_wdat",  o_word_data, 0);
        chk("rste_wlast", 32'(o_word_last), 0);
        chk("rste_done",  32'(o_done), 0);
        @(negedge i_clk);
        i_rst  = 1'b0;
        g_hold = 1'b0;
        @(negedge i_clk);

        // 6c: invalid widths raise err, never go busy
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            i_start = 1'b1;
            i_n     = (k == 0) ? 5'd0 : 5'd17;
            @(negedge i_clk);
            i_start = 1'b0;
            chk("err_pulse", 32'(o_err), 1);
            chk("err_busy",  32'(o_busy), 0);
            @(negedge i_clk);
            chk("err_clear", 32'(o_err), 0);
            chk("err_idle",  32'(o_busy), 0);
        end

        // A valid block after the error and resets still works.
        rand_words(12);
        transpose(12);
        push_words();
        run_block(12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
